// File: rtl/anubis_dec_key_sched.sv
// Anubis decryption key schedule: buffers the R+1 encryption round keys
// and replays them reversed, applying theta to every interior key.
module anubis_dec_key_sched #(
    parameter int ROUNDS = 12,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [127:0]      in_key,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [127:0]      out_key,
    output logic [CNT_W-1:0]  out_round,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic {LOAD, EMIT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS);

    state_t             state_q;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic [127:0]       key_mem_q [ROUNDS+1];
    logic [127:0]       out_key_q;
    logic [CNT_W-1:0]   out_round_q;
    logic               out_last_q;
    logic               out_valid_q;

    logic               in_acc;
    logic               out_hs;
    logic               ld;
    logic [CNT_W-1:0]   rd_idx;
    logic [127:0]       rd_key;
    logic [127:0]       map_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
    endfunction

    // H[k][j] depends only on k^j: 0->01, 1->02, 2->04, 3->06
    function automatic logic [127:0] theta(input logic [127:0] a);
        logic [127:0] r;
        logic [7:0]   b, m2, m4, m;
        logic [1:0]   sel;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 4; k++) begin
                    b   = a[8*(4*i+k) +: 8];
                    m2  = xtime(b);
                    m4  = xtime(m2);
                    sel = 2'(k ^ j);
                    unique case (sel)
                        2'd0:    m = b;
                        2'd1:    m = m2;
                        2'd2:    m = m4;
                        default: m = m4 ^ m2;
                    endcase
                    r[8*(4*i+j) +: 8] = r[8*(4*i+j) +: 8] ^ m;
                end
            end
        end
        return r;
    endfunction

    assign in_ready = rst_n && (state_q == LOAD);
    assign in_acc   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign ld       = (state_q == EMIT) && (out_cnt_q <= LAST)
                   && (!out_valid_q || out_ready);

    assign rd_idx = LAST - out_cnt_q;
    assign rd_key = key_mem_q[rd_idx];

    always_comb begin
        map_d = rd_key;
        if (out_cnt_q != '0 && out_cnt_q != LAST)
            map_d = theta(rd_key);
    end

    always_ff @(posedge clk) begin
        if (in_acc)
            key_mem_q[in_cnt_q] <= in_key;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            out_key_q   <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_acc) begin
                        if (in_cnt_q == LAST) begin
                            in_cnt_q <= '0;
                            state_q  <= EMIT;
                        end else begin
                            in_cnt_q <= in_cnt_q + CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (ld) begin
                        out_valid_q <= 1'b1;
                        out_round_q <= out_cnt_q;
                        out_last_q  <= (out_cnt_q == LAST);
                        out_key_q   <= map_d;
                        out_cnt_q   <= out_cnt_q + CNT_W'(1);
                    end else if (out_hs && out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        out_cnt_q   <= '0;
                        state_q     <= LOAD;
                    end
                end
            endcase
        end
    end

    assign out_key   = out_key_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_anubis_dec_key_sched.sv
// Self-checking bench for anubis_dec_key_sched against a GF(2^8)
// matrix-product reference of the decryption key mapping.
module tb_anubis_dec_key_sched;

    localparam int R = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [127:0]  in_key;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  out_key;
    logic [CW-1:0] out_round;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    logic [127:0] keys [R+1];
    logic [127:0] exp_q [R+1];
    logic [127:0] got [R+1];
    int           hs_cnt;
    int           cyc_cnt;

    anubis_dec_key_sched #(.ROUNDS(R), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_key(in_key),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_key(out_key),
        .out_round(out_round),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] x,
                                        input logic [7:0] y);
        logic [8:0] xx;
        logic [7:0] p;
        p  = 8'h00;
        xx = {1'b0, x};
        for (int n = 0; n < 8; n++) begin
            if (y[n]) p = p ^ xx[7:0];
            xx = xx << 1;
            if (xx[8]) xx = xx ^ 9'h11D;
        end
        return p;
    endfunction

    function automatic logic [127:0] theta_ref(input logic [127:0] k);
        logic [7:0] h [4][4];
        logic [7:0] a [4][4];
        logic [7:0] acc;
        logic [127:0] res;
        h = '{'{8'h01, 8'h02, 8'h04, 8'h06},
              '{8'h02, 8'h01, 8'h06, 8'h04},
              '{8'h04, 8'h06, 8'h01, 8'h02},
              '{8'h06, 8'h04, 8'h02, 8'h01}};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                a[i][j] = k[8*(4*i+j) +: 8];
        res = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int kk = 0; kk < 4; kk++)
                    acc = acc ^ gmul(a[i][kk], h[kk][j]);
                res[8*(4*i+j) +: 8] = acc;
            end
        return res;
    endfunction

    task automatic build_expect();
        for (int r = 0; r <= R; r++) begin
            if (r == 0)      exp_q[r] = keys[R];
            else if (r == R) exp_q[r] = keys[0];
            else             exp_q[r] = theta_ref(keys[R-r]);
        end
    endtask

    task automatic send(input logic [127:0] k, input int gap);
        int n;
        n = 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_key   = k;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input int gapped);
        for (int i = 0; i <= R; i++) begin
            if (gapped != 0 && i > 0) chk("load_not_emit", out_valid, 0);
            send(keys[i], gapped != 0 ? int'($urandom_range(0, 2)) : 0);
        end
        chk("lat_cycle1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_cycle2", out_valid, 1);
    endtask

    // rmode 0: always ready, 1: random ready. stop_at < R+1 aborts early.
    task automatic drain(input int rmode, input int stop_at);
        logic [127:0]  hk;
        logic [CW-1:0] hr;
        logic          hl;
        logic          stalled;
        int            n;
        hs_cnt  = 0;
        n       = 0;
        stalled = 1'b0;
        hk = '0; hr = '0; hl = 1'b0;
        while (hs_cnt < stop_at && n < 400) begin
            out_ready = (rmode == 0) ? 1'b1 : 1'(int'($urandom_range(0, 1)));
            chk("emit_in_ready", in_ready, 0);
            if (out_valid) begin
                if (stalled) begin
                    chk("stall_key", out_key, hk);
                    chk("stall_round", out_round, hr);
                    chk("stall_last", out_last, hl);
                end
                if (out_ready) begin
                    chk("out_key", out_key, exp_q[hs_cnt]);
                    chk("out_round", out_round, hs_cnt);
                    chk("out_last", out_last, hs_cnt == R);
                    got[hs_cnt] = out_key;
                    hs_cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hk = out_key; hr = out_round; hl = out_last;
                end
            end else begin
                chk("valid_gap", out_valid, 1);
            end
            @(posedge clk); #1;
            n++;
        end
        cyc_cnt   = n;
        out_ready = 1'b0;
        if (hs_cnt < stop_at) chk("drain_timeout", hs_cnt, stop_at);
    endtask

    task automatic post_drain();
        chk("done_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
    endtask

    task automatic rand_keys();
        for (int i = 0; i <= R; i++)
            keys[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [127:0] b2 [R+1];
        rst_n = 1'b0; in_key = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_round", out_round, 0);
        chk("rst_key", out_key, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // theta unit
        for (int i = 0; i <= R; i++) keys[i] = '0;
        keys[11] = 128'h80;
        build_expect();
        load(0);
        drain(0, R + 1);
        chk("t1_r1", got[1], 128'h273A1D80);
        chk("t1_r0", got[0], 0);
        chk("t1_rR", got[R], 0);
        post_drain();

        // ordering
        for (int i = 0; i <= R; i++) keys[i] = 128'(i);
        build_expect();
        load(0);
        drain(0, R + 1);
        chk("t2_r0", got[0], 128'h0C);
        chk("t2_r1", got[1], 128'h3A2C160B);
        chk("t2_r11", got[11], 128'h06040201);
        chk("t2_r12", got[12], 0);
        chk("t2_cycles", cyc_cnt, R + 1);
        post_drain();

        // backpressure
        load(0);
        drain(1, R + 1);
        post_drain();

        // gapped input, random keys, random ready
        rand_keys();
        build_expect();
        load(1);
        drain(1, R + 1);
        post_drain();

        // reset mid-emit
        rand_keys();
        build_expect();
        load(0);
        drain(0, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", in_ready, 1);
        chk("mid_rel_valid", out_valid, 0);
        rand_keys();
        build_expect();
        load(1);
        drain(1, R + 1);
        post_drain();

        // back-to-back with in_valid held across last handshake
        rand_keys();
        build_expect();
        load(0);
        for (int i = 0; i <= R; i++) b2[i] = {$urandom, $urandom, $urandom, $urandom};
        in_key   = b2[0];
        in_valid = 1'b1;
        drain(1, R + 1);
        chk("b2b_in_ready", in_ready, 1);
        for (int i = 0; i <= R; i++) keys[i] = b2[i];
        build_expect();
        load(0);
        drain(0, R + 1);
        post_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
